// File: rtl/bcd_display_feeder.sv
// Sequential double-dabble binary-to-BCD converter feeding a 4-digit display bus port.
// Optional feature: define BCD_SATURATE_EN to clamp values above 9999 to 16'h9999.
module bcd_display_feeder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [1:0]  data_addr,
  output logic [31:0] data_out,
  output logic        write_enable,
  output logic [1:0]  window_size
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t      r_state;
  logic [35:0] r_scratch;
  logic [3:0]  r_cnt;
  logic [15:0] r_pend_value;
  logic        r_pend_valid;
  logic        r_armed;
  logic        r_busy;
  logic        r_done;
  logic        r_overflow;
  logic [31:0] r_data_out;
  logic        r_write_enable;

  logic [35:0] w_dabbled;
  logic [35:0] w_step;
  logic [15:0] w_digits;
  logic        w_lost_digit;

  function automatic logic [19:0] add3_digits(input logic [19:0] bcd);
    logic [19:0] res;
    logic [3:0]  d;
    res = 20'h0;
    for (int i = 0; i < 5; i++) begin
      d = bcd[i*4 +: 4];
      if (d >= 4'd5) begin
        res[i*4 +: 4] = d + 4'd3;
      end else begin
        res[i*4 +: 4] = d;
      end
    end
    return res;
  endfunction

  // One double-dabble iteration and the display digits it would yield on the last step.
  always_comb begin
    w_dabbled    = {add3_digits(r_scratch[35:16]), r_scratch[15:0]};
    w_step       = w_dabbled << 6'd1;
    w_lost_digit = (w_step[35:32] != 4'd0);
`ifdef BCD_SATURATE_EN
    if (w_lost_digit) begin
      w_digits = 16'h9999;
    end else begin
      w_digits = w_step[31:16];
    end
`else
    w_digits = w_step[31:16];
`endif
  end

  // Conversion FSM with pending buffer; all outputs registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_scratch      <= 36'h0;
      r_cnt          <= 4'd0;
      r_pend_value   <= 16'h0;
      r_pend_valid   <= 1'b0;
      r_armed        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_overflow     <= 1'b0;
      r_data_out     <= 32'h0;
      r_write_enable <= 1'b0;
    end else begin
      // The first edge after reset release only arms the block, so a start there is dropped.
      r_armed        <= 1'b1;
      r_done         <= 1'b0;
      r_write_enable <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_armed && start) begin
            r_scratch <= {20'h0, value};
            r_cnt     <= 4'd0;
            r_state   <= ST_SHIFT;
            r_busy    <= 1'b1;
          end else begin
            r_busy    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_scratch <= w_step;
          r_cnt     <= r_cnt + 4'd1;
          r_busy    <= 1'b1;
          if (start) begin
            r_pend_value <= value;
            r_pend_valid <= 1'b1;
          end
          if (r_cnt == 4'd15) begin
            r_state        <= ST_WRITE;
            r_write_enable <= 1'b1;
            r_done         <= 1'b1;
            r_data_out     <= {16'h0, w_digits};
            r_overflow     <= w_lost_digit;
          end
        end
        ST_WRITE: begin
          // A start in this cycle is newer than anything buffered, so it wins.
          if (start) begin
            r_scratch    <= {20'h0, value};
            r_cnt        <= 4'd0;
            r_state      <= ST_SHIFT;
            r_pend_valid <= 1'b0;
            r_busy       <= 1'b1;
          end else if (r_pend_valid) begin
            r_scratch    <= {20'h0, r_pend_value};
            r_cnt        <= 4'd0;
            r_state      <= ST_SHIFT;
            r_pend_valid <= 1'b0;
            r_busy       <= 1'b1;
          end else begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_pend_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign overflow     = r_overflow;
  assign data_out     = r_data_out;
  assign write_enable = r_write_enable;
  assign data_addr    = 2'b00;
  assign window_size  = 2'b01;

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Scoreboard bench for bcd_display_feeder: stimulus pushes expected writes, a monitor pops on write_enable.
module tb_bcd_display_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [1:0]  data_addr;
  logic [31:0] data_out;
  logic        write_enable;
  logic [1:0]  window_size;

  bcd_display_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .value        (value),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .data_addr    (data_addr),
    .data_out     (data_out),
    .write_enable (write_enable),
    .window_size  (window_size)
  );

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic o, input int c);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Called at a negedge: start is sampled at the next posedge, whose cycle number is returned.
  task automatic pulse(input logic [15:0] v, output int e0);
    start = 1'b1;
    value = v;
    e0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((busy || exp_q.size() != 0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("idle_timeout", {31'h0, (budget >= 200)}, 32'h0);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("done_eq_we", {31'h0, done}, {31'h0, write_enable});
      if (write_enable) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", data_out, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data_out", data_out, e.data);
          chk("overflow", {31'h0, overflow}, {31'h0, e.ovf});
          chk("write_cycle", cyc, e.cyc);
          chk("data_addr", {30'h0, data_addr}, 32'h0);
          chk("window_size", {30'h0, window_size}, 32'h1);
          chk("busy_in_write", {31'h0, busy}, 32'h1);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_ovf"}, {31'h0, overflow}, 32'h0);
    chk({tag, "_we"}, {31'h0, write_enable}, 32'h0);
    chk({tag, "_data"}, data_out, 32'h0);
    chk({tag, "_addr"}, {30'h0, data_addr}, 32'h0);
    chk({tag, "_win"}, {30'h0, window_size}, 32'h1);
  endtask

  int e0;
  int e1;
  logic [31:0] big_exp;

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    value    = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic conversion with latency and busy timing
    pulse(16'd1234, e0);
    push_exp(32'h0000_1234, 1'b0, e0 + 16);
    chk("busy_after_start", {31'h0, busy}, 32'h1);
    wait_cyc(e0 + 16);
    chk("busy_at_write", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("busy_falls", {31'h0, busy}, 32'h0);
    chk("we_one_cycle", {31'h0, write_enable}, 32'h0);
    chk("data_hold", data_out, 32'h0000_1234);

    pulse(16'd0, e0);
    push_exp(32'h0000_0000, 1'b0, e0 + 16);
    wait_idle();
    pulse(16'd9999, e0);
    push_exp(32'h0000_9999, 1'b0, e0 + 16);
    wait_idle();

`ifdef BCD_SATURATE_EN
    big_exp = 32'h0000_9999;
`else
    big_exp = 32'h0000_5535;
`endif
    pulse(16'd65535, e0);
    push_exp(big_exp, 1'b1, e0 + 16);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ovf_holds", {31'h0, overflow}, 32'h1);
    chk("data_holds", data_out, big_exp);

    // start during the WRITE cycle is serviced straight after it
    pulse(16'd100, e0);
    push_exp(32'h0000_0100, 1'b0, e0 + 16);
    wait_cyc(e0 + 16);
    pulse(16'd200, e1);
    push_exp(32'h0000_0200, 1'b0, e1 + 16);
    wait_idle();

    // Pending buffer: 43 is overwritten by 44
    pulse(16'd42, e0);
    push_exp(32'h0000_0042, 1'b0, e0 + 16);
    push_exp(32'h0000_0044, 1'b0, e0 + 33);
    wait_cyc(e0 + 3);
    pulse(16'd43, e1);
    wait_cyc(e0 + 6);
    pulse(16'd44, e1);
    while (cyc <= e0 + 33) begin
      chk("busy_continuous", {31'h0, busy}, 32'h1);
      @(negedge clk);
    end
    chk("busy_after_pair", {31'h0, busy}, 32'h0);
    wait_idle();

`ifdef BCD_SATURATE_EN
    big_exp = 32'h0000_9999;
`else
    big_exp = 32'h0000_0000;
`endif
    pulse(16'd10000, e0);
    push_exp(big_exp, 1'b1, e0 + 16);
    wait_idle();

    // Reset during SHIFT discards the conversion
    pulse(16'd777, e0);
    wait_cyc(e0 + 8);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    value = 16'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check_reset_outputs("postrst");

    pulse(16'd5, e0);
    push_exp(32'h0000_0005, 1'b0, e0 + 16);
    wait_idle();

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
